dual_switch_debounce: RTL and testbench

Two-channel synchronizer and debouncer for the board's slide switches and push buttons. It takes raw asynchronous contact levels and produces clean, glitch-free, clock-synchronous levels `a_clean` and `b_clean`. These drive the `a`/`b` inputs of the lab's combinational gate stages (NOR/NAND De Morgan blocks), so every gate experiment sees stable operands. Optional single-cycle rise/fall pulses support counting and edge-triggered lab steps.

---
 rtl/debounce_pkg.sv | 14 +
 rtl/debounce_channel.sv | 103 ++++++++++
 rtl/dual_switch_debounce.sv | 51 +++++
 tb/tb_dual_switch_debounce.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state type and constants for the switch debouncer
package debounce_pkg;

   typedef enum logic [1:0] {
      S_LOW       = 2'd0,
      S_WAIT_HIGH = 2'd1,
      S_HIGH      = 2'd2,
      S_WAIT_LOW  = 2'd3
   } deb_state_t;

   localparam int DEFAULT_STABLE_CYCLES = 100000;
   localparam int SYNC_DEPTH            = 2;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one-bit synchronizer plus debounce FSM
// Edge pulse outputs rise/fall exist only when DEBOUNCE_EDGE_EN is defined.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic clean
`ifdef DEBOUNCE_EDGE_EN
 , output logic rise
 , output logic fall
`endif
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [SYNC_DEPTH-1:0] sync_q;
   logic                  sync;
   deb_state_t            state;
   logic [CNT_W-1:0]      cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_DEPTH-2:0], raw};
      end
   end

   assign sync = sync_q[SYNC_DEPTH-1];

   // Counter only runs in the WAIT states and is cleared on every exit,
   // so it tops out at STABLE_CYCLES-1 and cannot wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_LOW;
         cnt   <= '0;
         clean <= 1'b0;
`ifdef DEBOUNCE_EDGE_EN
         rise  <= 1'b0;
         fall  <= 1'b0;
`endif
      end else begin
`ifdef DEBOUNCE_EDGE_EN
         rise <= 1'b0;
         fall <= 1'b0;
`endif
         case (state)
            S_LOW: begin
               if (sync) begin
                  state <= S_WAIT_HIGH;
                  cnt   <= '0;
               end
            end
            S_WAIT_HIGH: begin
               if (!sync) begin
                  state <= S_LOW;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state <= S_HIGH;
                  clean <= 1'b1;
                  cnt   <= '0;
`ifdef DEBOUNCE_EDGE_EN
                  rise  <= 1'b1;
`endif
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_HIGH: begin
               if (!sync) begin
                  state <= S_WAIT_LOW;
                  cnt   <= '0;
               end
            end
            S_WAIT_LOW: begin
               if (sync) begin
                  state <= S_HIGH;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state <= S_LOW;
                  clean <= 1'b0;
                  cnt   <= '0;
`ifdef DEBOUNCE_EDGE_EN
                  fall  <= 1'b1;
`endif
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= S_LOW;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/dual_switch_debounce.sv
// rtl/dual_switch_debounce.sv - two independent debounced switch channels
// Edge pulse ports a_rise/a_fall/b_rise/b_fall exist only with DEBOUNCE_EDGE_EN.
module dual_switch_debounce
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic a_raw,
   input  logic b_raw,
   output logic a_clean,
   output logic b_clean
`ifdef DEBOUNCE_EDGE_EN
 , output logic a_rise
 , output logic a_fall
 , output logic b_rise
 , output logic b_fall
`endif
);

   debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
   ) u_chan_a (
      .clk   (clk),
      .rst   (rst),
      .raw   (a_raw),
      .clean (a_clean)
`ifdef DEBOUNCE_EDGE_EN
    , .rise  (a_rise)
    , .fall  (a_fall)
`endif
   );

   debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
   ) u_chan_b (
      .clk   (clk),
      .rst   (rst),
      .raw   (b_raw),
      .clean (b_clean)
`ifdef DEBOUNCE_EDGE_EN
    , .rise  (b_rise)
    , .fall  (b_fall)
`endif
   );

endmodule

// File: tb/tb_dual_switch_debounce.sv
// tb/tb_dual_switch_debounce.sv - randomized scoreboard bench for dual_switch_debounce
module tb_dual_switch_debounce;

   localparam int S  = 4;
   localparam int HL = S + 3;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic a_raw = 1'b0;
   logic b_raw = 1'b0;
   logic a_clean, b_clean;
`ifdef DEBOUNCE_EDGE_EN
   logic a_rise, a_fall, b_rise, b_fall;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dual_switch_debounce #(.STABLE_CYCLES(S)) dut (
      .clk     (clk),
      .rst     (rst),
      .a_raw   (a_raw),
      .b_raw   (b_raw),
      .a_clean (a_clean),
      .b_clean (b_clean)
`ifdef DEBOUNCE_EDGE_EN
    , .a_rise  (a_rise)
    , .a_fall  (a_fall)
    , .b_rise  (b_rise)
    , .b_fall  (b_fall)
`endif
   );

   typedef struct {
      bit a_clean;
      bit b_clean;
      bit a_rise;
      bit a_fall;
      bit b_rise;
      bit b_fall;
   } exp_t;

   exp_t exp_q[$];
   bit   hist_a[$];
   bit   hist_b[$];
   bit   ma, mb;

   task automatic check(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
      end
   endtask

   // Output flips to the other level once the raw samples taken from edge e-2-S
   // through edge e-2 all show that other level.
   function automatic bit flip_due(input bit h[$], input bit cur);
      for (int i = 0; i <= S; i++)
         if (h[HL-3-i] == cur) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk) begin : model
      exp_t e;
      bit   fa, fb;
      e = '{default: 1'b0};
      if (rst) begin
         hist_a = {};
         hist_b = {};
         for (int i = 0; i < HL; i++) begin
            hist_a.push_back(1'b0);
            hist_b.push_back(1'b0);
         end
         ma = 1'b0;
         mb = 1'b0;
      end else begin
         hist_a.push_back(a_raw);
         void'(hist_a.pop_front());
         hist_b.push_back(b_raw);
         void'(hist_b.pop_front());
         fa = flip_due(hist_a, ma);
         fb = flip_due(hist_b, mb);
         e.a_rise = fa && !ma;
         e.a_fall = fa && ma;
         e.b_rise = fb && !mb;
         e.b_fall = fb && mb;
         ma = ma ^ fa;
         mb = mb ^ fb;
      end
      e.a_clean = ma;
      e.b_clean = mb;
      exp_q.push_back(e);
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("a_clean", a_clean, e.a_clean);
         check("b_clean", b_clean, e.b_clean);
`ifdef DEBOUNCE_EDGE_EN
         check("a_rise", a_rise, e.a_rise);
         check("a_fall", a_fall, e.a_fall);
         check("b_rise", b_rise, e.b_rise);
         check("b_fall", b_fall, e.b_fall);
`endif
      end
   end

   task automatic settle(input logic a, input logic b);
      @(negedge clk);
      a_raw = a;
      b_raw = b;
      repeat (HL + 3) @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      repeat (10) @(negedge clk);

      // clean step on A: rises at edge S+3 after the change
      a_raw = 1'b1;
      repeat (S + 2) @(negedge clk);
      check("step_a_before", a_clean, 1'b0);
      check("step_b_quiet", b_clean, 1'b0);
      @(negedge clk);
      check("step_a_at_edge", a_clean, 1'b1);
      settle(1'b1, 1'b1);

      // asynchronous reset with both inputs high
      #2 rst = 1'b1;
      #1;
      check("rst_a_immediate", a_clean, 1'b0);
      check("rst_b_immediate", b_clean, 1'b0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      repeat (S + 2) @(negedge clk);
      check("rel_a_before", a_clean, 1'b0);
      check("rel_b_before", b_clean, 1'b0);
      @(negedge clk);
      check("rel_a_at_edge", a_clean, 1'b1);
      check("rel_b_at_edge", b_clean, 1'b1);

      // bounce on A from low
      settle(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         a_raw = (i % 2 == 0);
         repeat (2) @(negedge clk);
      end
      a_raw = 1'b1;
      repeat (HL + 3) @(negedge clk);

      // short glitch while high
      a_raw = 1'b0;
      repeat (3) @(negedge clk);
      a_raw = 1'b1;
      repeat (HL + 3) @(negedge clk);
      check("glitch_hold", a_clean, 1'b1);

      // both channels rise together, A falls later
      settle(1'b0, 1'b0);
      a_raw = 1'b1;
      b_raw = 1'b1;
      repeat (20) @(negedge clk);
      a_raw = 1'b0;
      repeat (HL + 3) @(negedge clk);
      check("indep_b_high", b_clean, 1'b1);

      // reset inside the wait window
      settle(1'b0, 1'b0);
      a_raw = 1'b1;
      repeat (4) @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (HL + 5) @(negedge clk);

      // random activity on both channels
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) a_raw = ~a_raw;
         if ($urandom_range(0, 5) == 0) b_raw = ~b_raw;
         if ($urandom_range(0, 400) == 0) begin
            #1 rst = 1'b1;
            @(negedge clk);
            #1 rst = 1'b0;
         end
      end
      repeat (HL + 3) @(negedge clk);

      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
